// File: rtl/ysyx_22040759_pkg.sv
// Shared definitions for the fetch-to-decode path: default widths, the bubble
// instruction and slice helpers for the {inst, pc} fetch bus.
`define YSYX_22040759_BUS_INST(bus, xlen, ilen) bus[(ilen)+(xlen)-1:(xlen)]
`define YSYX_22040759_BUS_PC(bus, xlen) bus[(xlen)-1:0]

package ysyx_22040759_pkg;
   localparam int          XLEN_DEF       = 64;
   localparam int          ILEN_DEF       = 32;
   localparam int          FS_TO_DS_BUS_W = ILEN_DEF + XLEN_DEF;
   localparam logic [31:0] NOP_INST       = 32'h0000_0013;
endpackage

// File: rtl/ysyx_22040759_ibuf_mem.sv
// Instruction buffer storage: one write port, one asynchronous read port.
// Entries carry no reset; validity is tracked by the owner.
module ysyx_22040759_ibuf_mem #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 96,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);
   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/ysyx_22040759_ds_ibuf.sv
// Fetch-to-decode instruction queue: presents the head packet to decode, injects
// NOP bubbles on stall or when empty, and discards everything on flush.
module ysyx_22040759_ds_ibuf #(
   parameter int           XLEN         = ysyx_22040759_pkg::XLEN_DEF,
   parameter int           ILEN         = ysyx_22040759_pkg::ILEN_DEF,
   parameter int           DEPTH        = 4,
   parameter logic [ILEN-1:0] NOP_INST  = ILEN'(ysyx_22040759_pkg::NOP_INST),
   parameter bit           PASS_ON_FULL = 1'b1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         fs_to_ds_valid,
   input  logic [ILEN+XLEN-1:0]         fs_to_ds_bus,
   output logic                         ds_allowin,
   input  logic                         flush,
   input  logic                         stall,
   input  logic                         es_allowin,
   output logic                         ds_to_es_valid,
   output logic [ILEN-1:0]              ds_inst,
   output logic [XLEN-1:0]              ds_pc,
   output logic                         ds_bubble,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int BUS_W = ILEN + XLEN;
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [CNT_W-1:0] count_reg, count_next;
   logic [BUS_W-1:0] head_entry;
   logic             has_head, full, push, pop;

   assign has_head = (count_reg != '0);
   assign full     = (count_reg == CNT_W'(DEPTH));

   assign ds_to_es_valid = has_head && !stall && !flush;
   assign pop            = ds_to_es_valid && es_allowin;

   generate
      if (PASS_ON_FULL) begin : g_pass_on_full
         // A full queue can still take a packet when the head leaves this cycle.
         assign ds_allowin = !full || (es_allowin && !stall && !flush);
      end else begin : g_strict_full
         assign ds_allowin = !full;
      end
   endgenerate

   assign push = fs_to_ds_valid && ds_allowin && !flush;

   ysyx_22040759_ibuf_mem #(
      .DEPTH (DEPTH),
      .WIDTH (BUS_W),
      .AW    (PTR_W)
   ) u_mem (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr_reg),
      .wdata (fs_to_ds_bus),
      .raddr (rd_ptr_reg),
      .rdata (head_entry)
   );

   always_comb begin
      ds_inst   = NOP_INST;
      ds_pc     = '0;
      ds_bubble = 1'b1;
      if (has_head && !stall) begin
         ds_inst   = `YSYX_22040759_BUS_INST(head_entry, XLEN, ILEN);
         ds_pc     = `YSYX_22040759_BUS_PC(head_entry, XLEN);
         ds_bubble = 1'b0;
      end
   end

   always_comb begin
      count_next = count_reg;
      case ({push, pop})
         2'b10:   count_next = count_reg + CNT_W'(1);
         2'b01:   count_next = count_reg - CNT_W'(1);
         default: count_next = count_reg;
      endcase
   end

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (flush) begin
         rd_ptr_reg <= wr_ptr_reg;
         count_reg  <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         count_reg <= count_next;
      end
   end

   assign count = count_reg;
endmodule

// File: doc/ysyx_22040759_ds_ibuf.md
# ysyx_22040759_ds_ibuf

Parametrised fetch-to-decode instruction buffer that replaces the single-entry IF/ID pipeline register with a DEPTH-entry queue. It accepts {inst, pc} packets from the fetch stage over the valid/allowin handshake and presents the head entry to decode. It supports hazard stall with NOP bubble injection and a single-cycle flush on branch taken. It sits between the fetch stage and the decode logic.

## Interface
- XLEN, 64, PC width
- ILEN, 32, instruction width
- DEPTH, 4, queue entries; power of two, ≥2
- NOP_INST, 32'h13, instruction presented when no valid head (addi x0,x0,0)
- PASS_ON_FULL, 1, 1: accept a push while full if the head pops the same cycle; 0: accept only when count<DEPTH
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- fs_to_ds_valid  in  1  fetch packet valid
- fs_to_ds_bus  in  ILEN+XLEN  {inst[ILEN+XLEN-1:XLEN], pc[XLEN-1:0]}
- ds_allowin  out  1  buffer can accept a packet this cycle
- flush  in  1  branch taken: discard all entries
- stall  in  1  hazard: hold head, inject bubble
- es_allowin  in  1  execute stage accepts
- ds_to_es_valid  out  1  head valid and not stalled
- ds_inst  out  ILEN  head instruction, or NOP_INST
- ds_pc  out  XLEN  head PC, or 0
- ds_bubble  out  1  ds_inst/ds_pc are an injected bubble
- count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Circular buffer; wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap mod DEPTH; count is tracked separately (full = count==DEPTH, empty = count==0).
- pop = ds_to_es_valid && es_allowin.
- ds_to_es_valid = (count!=0) && !stall && !flush.
- ds_allowin:
  - PASS_ON_FULL=0: count<DEPTH.
  - PASS_ON_FULL=1: count<DEPTH || (es_allowin && !stall && !flush).
- push = fs_to_ds_valid && ds_allowin && !flush.
- Output mux:
  - When count!=0 && !stall: ds_inst/ds_pc = head entry, ds_bubble=0.
  - Otherwise: ds_inst=NOP_INST, ds_pc=0, ds_bubble=1.
- push and pop in the same cycle: count unchanged, both pointers advance.
- flush: next cycle count=0 and rd_ptr=wr_ptr. A same-cycle push is dropped and no pop occurs; flush has priority over all other inputs.
- stall and flush together: flush wins.
- stall: head and count are held; pushes continue while space remains.
- Storage entries are not reset; their contents are don't-care while invalid.

## Timing
- Reset (async assert) values: count=0, wr_ptr=rd_ptr=0, ds_to_es_valid=0, ds_inst=NOP_INST, ds_pc=0, ds_bubble=1, ds_allowin=1.
- Push-to-head latency: 1 cycle. A packet pushed at edge N is visible on ds_inst after edge N; there is no same-cycle bypass.
- Throughput: 1 packet/cycle sustained when es_allowin is held high.
- ds_to_es_valid, ds_inst, ds_pc and ds_bubble are combinational from registered state plus stall/flush; no combinational path from fs_to_ds_valid.
- ds_allowin depends combinationally on es_allowin, stall and flush only when PASS_ON_FULL=1.
- Reset asserted mid-operation: all entries are discarded immediately (asynchronously); the first push is accepted on the first edge after deassertion.

## Structure
- Shared package ysyx_22040759_pkg holds:
  - NOP_INST constant
  - localparams FS_TO_DS_BUS_W = ILEN+XLEN
  - field-slice macros for inst/pc
- One sub-module, ysyx_22040759_ibuf_mem: a DEPTH × (ILEN+XLEN) register array with one write port and one asynchronous read port, and no reset.
- Pointer, count, handshake and bubble logic live in the top module.

## Test plan
- Reset, then push pc=0x80000000 inst=0x00100093 with es_allowin=0 → next cycle count=1, ds_to_es_valid=1, ds_inst=0x00100093, ds_bubble=0.
- Push 4 packets with es_allowin=0, DEPTH=4, PASS_ON_FULL=0 → count=4, ds_allowin=0. Raise es_allowin → packets pop in order pc 0x80000000/04/08/0C, one per cycle.
- Full buffer, PASS_ON_FULL=1, es_allowin=1, fs_to_ds_valid=1 every cycle → ds_allowin=1 and count stays 4 for 10 cycles with zero loss.
- Queue holding 3 entries, stall=1 for 2 cycles → ds_inst=0x13, ds_pc=0, ds_bubble=1, ds_to_es_valid=0, count=3. Release stall → the original head reappears.
- Queue holding 3 entries, flush=1 with a simultaneous fs_to_ds_valid → next cycle count=0 and ds_inst=0x13. The dropped packet never appears at the output.
- Assert rst asynchronously mid-burst (between edges) → outputs take their reset values before the next clk edge; after deassert, push pc=0x80000100 → it appears as head with count=1.
